// File: rtl/avalon_icache_pkg.sv
// rtl/avalon_icache_pkg.sv - shared types and default geometry for the instruction cache
package avalon_icache_pkg;

  // Default geometry; the cache module re-derives its widths from its own parameters.
  localparam int DEF_LINES          = 16;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int OFFSET_W           = $clog2(DEF_WORDS_PER_LINE);
  localparam int INDEX_W            = $clog2(DEF_LINES);
  localparam int TAG_W              = 32 - INDEX_W - OFFSET_W - 2;

  // Two-state controller: serving hits, or burst-filling one line.
  typedef logic [0:0] icache_state_t;
  localparam icache_state_t IDLE = 1'b0;
  localparam icache_state_t FILL = 1'b1;

  // Byte address as seen by the cache for the default geometry.
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [1:0]          byte_sel;
  } icache_addr_t;

endpackage

// File: rtl/icache_data_store.sv
// rtl/icache_data_store.sv - line data RAM with one write port and a registered read port
module icache_data_store #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Fill writes and hit reads; the registered read gives the one-cycle hit latency.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avalon_icache.sv
// rtl/avalon_icache.sv - direct-mapped read-only instruction cache with Avalon-MM agent and host sides
module avalon_icache
  import avalon_icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] cpu_address,
  input  logic [3:0]  cpu_byteenable,
  input  logic        cpu_read,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readdatavalid,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);

  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - OW - 2;
  localparam int LW = TW + IW;
  localparam int CW = OW + 1;

  logic [IW-1:0]  cpu_idx;
  logic [OW-1:0]  cpu_off;
  logic [TW-1:0]  cpu_tag;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]  tag_q [LINES];
  icache_state_t  state_q;
  logic [LW-1:0]  line_q;
  logic [CW-1:0]  issue_q;
  logic [CW-1:0]  ret_q;
  logic           poison_q;
  logic           rvalid_q;
  logic           in_idle;
  logic           hit;
  logic           accept_hit;
  logic           miss;
  logic           beat;
  logic           last_beat;
  logic [IW-1:0]  fill_idx;
  logic [TW-1:0]  fill_tag;
  logic [31:0]    ram_rdata;
  logic           unused_ok;

  assign cpu_idx  = cpu_address[OW+2 +: IW];
  assign cpu_off  = cpu_address[2 +: OW];
  assign cpu_tag  = cpu_address[31 -: TW];
  assign fill_idx = line_q[IW-1:0];
  assign fill_tag = line_q[LW-1:IW];

  // Byte lanes and the low address bits never affect a whole-word fetch.
  assign unused_ok = ^{cpu_byteenable, cpu_address[1:0]};

  assign in_idle    = (state_q == IDLE);
  assign hit        = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign accept_hit = in_idle && cpu_read && hit;
  assign miss       = in_idle && cpu_read && !hit;

  // The CPU is held off during reset, during any fill, and on an IDLE miss.
  assign cpu_waitrequest   = rst || !in_idle || (cpu_read && !hit);
  assign cpu_readdatavalid = rvalid_q;
  assign cpu_readdata      = rvalid_q ? ram_rdata : 32'h0;

  assign mem_byteenable = 4'hF;
  assign mem_read       = !in_idle && (issue_q < CW'(WORDS_PER_LINE));
  assign mem_address    = mem_read ? {line_q, issue_q[OW-1:0], 2'b00} : 32'h0;

  // Returns arrive in request order, so the return count is the word slot.
  assign beat      = !in_idle && mem_readdatavalid;
  assign last_beat = beat && (ret_q == CW'(WORDS_PER_LINE - 1));

  icache_data_store #(
    .DEPTH(LINES * WORDS_PER_LINE),
    .AW   (IW + OW)
  ) u_data (
    .clk    (clk),
    .we_i   (beat),
    .waddr_i({fill_idx, ret_q[OW-1:0]}),
    .wdata_i(mem_readdata),
    .raddr_i({cpu_idx, cpu_off}),
    .rdata_o(ram_rdata)
  );

  // Controller: hit acknowledge, miss launch, issue/return counting and line validation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= '0;
      line_q   <= '0;
      issue_q  <= '0;
      ret_q    <= '0;
      poison_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= accept_hit;
      if (in_idle) begin
        if (flush) begin
          valid_q <= '0;
        end
        if (miss) begin
          line_q           <= cpu_address[31:OW+2];
          valid_q[cpu_idx] <= 1'b0;
          issue_q          <= '0;
          ret_q            <= '0;
          poison_q         <= 1'b0;
          state_q          <= FILL;
        end
      end else begin
        // A flush during a fill cannot cancel reads already in flight; it only
        // stops the line from being marked valid when the fill lands.
        if (flush) begin
          poison_q <= 1'b1;
        end
        if (mem_read && !mem_waitrequest) begin
          issue_q <= issue_q + CW'(1);
        end
        if (beat) begin
          ret_q <= ret_q + CW'(1);
        end
        if (last_beat) begin
          valid_q[fill_idx] <= !(poison_q || flush);
          issue_q           <= '0;
          ret_q             <= '0;
          state_q           <= IDLE;
        end
      end
    end
  end

  // Tag update on fill completion; tags are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_avalon_icache.sv
// tb/tb_avalon_icache.sv - self-checking bench for avalon_icache with a latency-2 memory model
module tb_avalon_icache;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] cpu_address = 32'h0;
  logic [3:0]  cpu_byteenable = 4'hF;
  logic        cpu_read = 1'b0;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        cpu_readdatavalid;
  logic [31:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] mem_readdata = 32'h0;
  logic        mem_readdatavalid = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  avalon_icache dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .cpu_address      (cpu_address),
    .cpu_byteenable   (cpu_byteenable),
    .cpu_read         (cpu_read),
    .cpu_waitrequest  (cpu_waitrequest),
    .cpu_readdata     (cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_read         (mem_read),
    .mem_waitrequest  (mem_waitrequest),
    .mem_readdata     (mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } acc_t;

  pend_t       pend[$];
  acc_t        acc_q[$];
  int          cyc = 0;
  bit          rand_ws = 0;
  logic [31:0] stall_addr = 32'h0;
  int          stall_left = 0;
  bit          stray_req = 0;
  bit          stray_now = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = 32'h0;
  bit          rst_edge;

  always @(posedge clk) begin
    rst_edge = rst;
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_readdatavalid && !stray_now && pend.size() > 0) void'(pend.pop_front());
      if (mem_read && !mem_waitrequest) begin
        pend.push_back('{mem_address, cyc + 2});
        acc_q.push_back('{mem_address, cyc});
      end
    end
    cyc++;
    #1;
    if (prev_stall && !rst_edge) begin
      n_cmp++;
      if (mem_read !== 1'b1 || mem_address !== prev_addr) begin
        n_fail++;
        $display("FAIL stall_hold: mem_read=%b mem_address=%h required mem_read=1 mem_address=%h",
                 mem_read, mem_address, prev_addr);
      end
    end
    stray_now = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = pend[0].addr ^ KEY;
    end else if (stray_req) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = $urandom;
      stray_now         = 1;
      stray_req         = 0;
    end else begin
      mem_readdatavalid = 1'b0;
      mem_readdata      = $urandom;
    end
    if (mem_read && mem_address == stall_addr && stall_left > 0) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end else begin
      mem_waitrequest = rand_ws ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    prev_stall = mem_read && mem_waitrequest && !rst;
    prev_addr  = mem_address;
  end

  // ---------------- cache reference model ----------------
  bit          mv[16];
  logic [23:0] mt[16];

  function automatic bit model_hit(input logic [31:0] a);
    return mv[a[7:4]] && (mt[a[7:4]] == a[31:8]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    mv[a[7:4]] = 1;
    mt[a[7:4]] = a[31:8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 0;
  endtask

  // ---------------- CPU driver ----------------
  // Called at a negedge; returns at the negedge where the read data beat is visible.
  task automatic do_read(input logic [31:0] a, input int flush_at, output int stalls, output int nacc);
    int          start;
    logic [31:0] exp;
    start  = acc_q.size();
    exp    = {a[31:2], 2'b00} ^ KEY;
    stalls = 0;
    cpu_read       = 1'b1;
    cpu_address    = a;
    cpu_byteenable = 4'($urandom);
    flush          = (flush_at == 0);
    #1;
    while (cpu_waitrequest === 1'b1 && stalls < 200) begin
      if (stalls > 0) begin
        n_cmp++;
        if (cpu_readdatavalid !== 1'b0) begin
          n_fail++;
          $display("FAIL rvalid_in_fill: addr=%h readdatavalid=%b required 0", a, cpu_readdatavalid);
        end
      end
      @(negedge clk);
      stalls++;
      flush = (stalls == flush_at);
      #1;
    end
    n_cmp++;
    if (stalls >= 200) begin
      n_fail++;
      $display("FAIL read_timeout: addr=%h still waiting after %0d cycles, required acceptance", a, stalls);
    end
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (cpu_readdatavalid !== 1'b1 || cpu_readdata !== exp) begin
      n_fail++;
      $display("FAIL read_data: addr=%h valid=%b data=%h required valid=1 data=%h",
               a, cpu_readdatavalid, cpu_readdata, exp);
    end
    nacc = acc_q.size() - start;
  endtask

  task automatic cpu_idle(input int n);
    cpu_read = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Checks that the last `count` accepted memory requests walk the line of `a` in order.
  task automatic check_fill_order(input logic [31:0] a, input int count, input string tag);
    int          s;
    logic [31:0] exp;
    s = acc_q.size() - count;
    for (int i = 0; i < count; i++) begin
      exp = {a[31:4], 4'h0} + 32'(4 * (i % 4));
      n_cmp++;
      if (acc_q[s + i].addr !== exp) begin
        n_fail++;
        $display("FAIL %s_order[%0d]: mem_address=%h required %h", tag, i, acc_q[s + i].addr, exp);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cpu_waitrequest !== 1'b1 || cpu_readdatavalid !== 1'b0 || cpu_readdata !== 32'h0 ||
        mem_read !== 1'b0 || mem_address !== 32'h0 || mem_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_outputs: wait=%b rv=%b rd=%h mr=%b ma=%h be=%h required 1 0 0 0 0 f",
               cpu_waitrequest, cpu_readdatavalid, cpu_readdata, mem_read, mem_address, mem_byteenable);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (cpu_waitrequest !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_wait: cpu_waitrequest=%b required 0 with cpu_read=0", cpu_waitrequest);
    end
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_first_miss();
    int st, na, s;
    do_read(32'h100, -1, st, na);
    check_int("first_miss_stalls", st, 7);
    check_int("first_miss_reqs", na, 4);
    check_fill_order(32'h100, 4, "first_miss");
    s = acc_q.size() - 4;
    for (int i = 1; i < 4; i++) check_int("first_miss_consecutive", acc_q[s + i].cyc - acc_q[s].cyc, i);
    model_fill(32'h100);
  endtask

  task automatic test_back_to_back();
    int st, na;
    logic [31:0] addrs[3];
    addrs[0] = 32'h104; addrs[1] = 32'h108; addrs[2] = 32'h10C;
    foreach (addrs[i]) begin
      do_read(addrs[i], -1, st, na);
      check_int("b2b_stalls", st, 0);
      check_int("b2b_reqs", na, 0);
    end
    cpu_idle(1);
  endtask

  task automatic test_conflict();
    int st, na;
    do_read(32'h200, -1, st, na);
    check_int("conflict_reqs", na, 4);
    check_fill_order(32'h200, 4, "conflict");
    model_fill(32'h200);
    cpu_idle(1);
    do_read(32'h100, -1, st, na);
    check_int("conflict_remiss_reqs", na, 4);
    model_fill(32'h100);
    cpu_idle(1);
  endtask

  task automatic test_mem_stall();
    int st, na;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
    stall_addr = 32'h104;
    stall_left = 3;
    do_read(32'h100, -1, st, na);
    check_int("stall_reqs", na, 4);
    check_int("stall_stalls", st, 10);
    check_fill_order(32'h100, 4, "stall");
    model_fill(32'h100);
    cpu_idle(1);
  endtask

  task automatic test_flush_in_fill();
    int st, na;
    do_read(32'h300, 2, st, na);
    check_int("flush_fill_reqs", na, 8);
    check_fill_order(32'h300, 8, "flush_fill");
    model_fill(32'h300);
    cpu_idle(1);
    do_read(32'h300, -1, st, na);
    check_int("after_flush_fill_hit", na, 0);
    cpu_idle(1);
  endtask

  task automatic test_flush_with_hit();
    int st, na;
    do_read(32'h304, 0, st, na);
    check_int("flush_hit_stalls", st, 0);
    model_clear();
    cpu_idle(1);
    do_read(32'h308, -1, st, na);
    check_int("flush_hit_remiss", na, 4);
    model_fill(32'h308);
    cpu_idle(1);
  endtask

  task automatic test_stray();
    int st, na;
    stray_req = 1;
    cpu_idle(3);
    do_read(32'h30C, -1, st, na);
    check_int("stray_hit_reqs", na, 0);
    cpu_idle(1);
  endtask

  task automatic test_reset_mid_fill();
    int st, na;
    cpu_read    = 1'b1;
    cpu_address = 32'h500;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_read !== 1'b0 || cpu_waitrequest !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_fill: mem_read=%b cpu_waitrequest=%b required 0 1", mem_read, cpu_waitrequest);
    end
    rst = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk);
    model_clear();
    do_read(32'h100, -1, st, na);
    check_int("post_reset_miss", na, 4);
    model_fill(32'h100);
    cpu_idle(1);
  endtask

  task automatic test_random();
    int st, na;
    logic [31:0] a;
    bit exp_hit;
    rand_ws = 1;
    for (int n = 0; n < 80; n++) begin
      a = {22'($urandom_range(0, 2)), 4'($urandom), 4'($urandom), 2'($urandom)};
      exp_hit = model_hit(a);
      do_read(a, -1, st, na);
      check_int("rand_reqs", na, exp_hit ? 0 : 4);
      if (exp_hit) check_int("rand_hit_stalls", st, 0);
      else check_fill_order(a, 4, "rand");
      model_fill(a);
      if ($urandom_range(0, 2) == 0) begin
        cpu_read = 1'b0;
        if ($urandom_range(0, 7) == 0) begin
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0;
          model_clear();
        end
        cpu_idle($urandom_range(1, 2));
      end
    end
    rand_ws = 0;
    cpu_idle(1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_conflict();
    test_mem_stall();
    test_flush_in_fill();
    test_flush_with_hit();
    test_stray();
    test_reset_mid_fill();
    test_random();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
